ro_puf_array: RTL

RO_PUF_ARRAY -- requirements
Module: ro_puf_array

---
 rtl/ro_puf_pkg.sv | 26 ++
 rtl/ro_edge_counter.sv | 46 ++++
 rtl/ro_ring.sv | 26 ++
 rtl/ro_puf_array.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ro_puf_pkg.sv
// ro_puf_pkg: shared definitions for the ring-oscillator PUF array.
// Holds the evaluation FSM state encoding, default parameter values
// and a small elaboration-time helper.
package ro_puf_pkg;

  localparam int DEF_NUM_RO        = 16;
  localparam int DEF_STAGES        = 24;
  localparam int DEF_CNT_WIDTH     = 16;
  localparam int DEF_SETTLE_CYCLES = 16;
  localparam int DEF_WINDOW_CYCLES = 4096;
  localparam int DEF_USE_EXT_RO    = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_COUNT   = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } puf_state_e;

  // Larger of two integers, used to size the shared phase timer.
  function automatic int max_int(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// ro_edge_counter: brings an asynchronous ring output into the clk
// domain, detects its rising edges and counts them with saturation.
// The synchronizer runs continuously so the edge detector already holds
// a valid previous sample when counting is enabled.
module ro_edge_counter
  import ro_puf_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ring_in,
  input  logic                 clr,
  input  logic                 cnt_en,
  output logic [CNT_WIDTH-1:0] count
);

  logic [1:0] sync_q;
  logic       prev_q;
  logic       rise;

  // Two-flop synchronizer followed by the edge-detect history flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], ring_in};
      prev_q <= sync_q[1];
    end
  end

  assign rise = sync_q[1] & ~prev_q;

  // Saturating edge counter; clear has priority over counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (cnt_en && rise && (count != {CNT_WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ro_ring.sv
// ro_ring: free-running ring oscillator with a halt input.
// The NOR gate closes the loop: enable=1 pins the first node low and
// stops the ring; enable=0 lets it oscillate. STAGES (even) inverters
// plus the NOR give an odd inversion count around the loop.
module ro_ring
  import ro_puf_pkg::*;
#(
  parameter int STAGES = DEF_STAGES
) (
  input  logic enable,
  output logic ro_out
);

  logic [STAGES:0] node;

  // Gated loop closure.
  assign node[0] = ~(node[STAGES] | enable);

  for (genvar g = 0; g < STAGES; g++) begin : g_inv
    // One inverter stage of the chain.
    assign node[g+1] = ~node[g];
  end

  assign ro_out = node[STAGES];

endmodule

// File: rtl/ro_puf_array.sv
// ro_puf_array: ring-oscillator PUF. A challenge selects two rings; both
// are released, allowed to warm up, then their rising edges are counted
// over a fixed window. The response bit says which ring ran faster.
//
// state      | meaning
// -----------+-----------------------------------------------------
// S_IDLE     | waiting for Start; all rings halted
// S_SETTLE   | selected rings running, counters held at zero
// S_COUNT    | selected rings running, counters accumulate edges
// S_COMPARE  | window closed; counts compared and results registered
// S_DONE     | result visible; Done pulses on the following cycle
module ro_puf_array
  import ro_puf_pkg::*;
#(
  parameter int NUM_RO        = DEF_NUM_RO,
  parameter int STAGES        = DEF_STAGES,
  parameter int CNT_WIDTH     = DEF_CNT_WIDTH,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int USE_EXT_RO    = DEF_USE_EXT_RO
) (
  input  logic                           Clock,
  input  logic                           Reset,
  input  logic                           Start,
  input  logic [2*$clog2(NUM_RO)-1:0]    Challenge,
  input  logic [NUM_RO-1:0]              Ro_Ext,
  output logic                           Busy,
  output logic                           Done,
  output logic                           Response,
  output logic                           Tie,
  output logic                           Error,
  output logic [CNT_WIDTH-1:0]           Count_A,
  output logic [CNT_WIDTH-1:0]           Count_B
);

  localparam int SEL_W   = $clog2(NUM_RO);
  localparam int TMR_MAX = max_int(SETTLE_CYCLES, WINDOW_CYCLES);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_SETTLE  = ST_SETTLE;
  localparam logic [2:0] S_COUNT   = ST_COUNT;
  localparam logic [2:0] S_COMPARE = ST_COMPARE;
  localparam logic [2:0] S_DONE    = ST_DONE;

  logic [2:0]           state;
  logic [TMR_W-1:0]     timer;
  logic [SEL_W-1:0]     idx_a;
  logic [SEL_W-1:0]     idx_b;
  logic [SEL_W-1:0]     chal_a;
  logic [SEL_W-1:0]     chal_b;
  logic                 chal_ok;
  logic                 accept;
  logic                 rings_run;
  logic [NUM_RO-1:0]    ring_en;
  logic [NUM_RO-1:0]    ro_raw;
  logic                 ro_a;
  logic                 ro_b;
  logic [CNT_WIDTH-1:0] cnt_a;
  logic [CNT_WIDTH-1:0] cnt_b;

  assign chal_a  = Challenge[2*SEL_W-1:SEL_W];
  assign chal_b  = Challenge[SEL_W-1:0];
  assign chal_ok = (chal_a != chal_b)
                && (32'(chal_a) < NUM_RO)
                && (32'(chal_b) < NUM_RO);

  // Start is only honoured in IDLE; everywhere else it is ignored.
  assign accept    = (state == S_IDLE) && Start;
  assign rings_run = (state == S_SETTLE) || (state == S_COUNT);
  assign Busy      = (state == S_SETTLE) || (state == S_COUNT) || (state == S_COMPARE);

  // Release only the two selected rings while settling and counting.
  always_comb begin
    ring_en = '1;
    for (int i = 0; i < NUM_RO; i++) begin
      if (rings_run && ((SEL_W'(i) == idx_a) || (SEL_W'(i) == idx_b))) begin
        ring_en[i] = 1'b0;
      end
    end
  end

  if (USE_EXT_RO == 0) begin : g_rings
    for (genvar r = 0; r < NUM_RO; r++) begin : g_ro
      ro_ring #(
        .STAGES (STAGES)
      ) u_ro (
        .enable (ring_en[r]),
        .ro_out (ro_raw[r])
      );
    end
    logic unused_ext;
    assign unused_ext = ^Ro_Ext;
  end else begin : g_ext
    assign ro_raw = Ro_Ext;
    logic unused_en;
    assign unused_en = ^ring_en;
  end

  // Route the two selected ring outputs to the counters.
  always_comb begin
    ro_a = 1'b0;
    ro_b = 1'b0;
    for (int i = 0; i < NUM_RO; i++) begin
      if (SEL_W'(i) == idx_a) ro_a = ro_raw[i];
      if (SEL_W'(i) == idx_b) ro_b = ro_raw[i];
    end
  end

  ro_edge_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_cnt_a (
    .clk     (Clock),
    .rst     (Reset),
    .ring_in (ro_a),
    .clr     (accept && chal_ok),
    .cnt_en  (state == S_COUNT),
    .count   (cnt_a)
  );

  ro_edge_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_cnt_b (
    .clk     (Clock),
    .rst     (Reset),
    .ring_in (ro_b),
    .clr     (accept && chal_ok),
    .cnt_en  (state == S_COUNT),
    .count   (cnt_b)
  );

  // Evaluation sequencer, phase timer and registered result outputs.
  // Done is registered from S_DONE, so it lands one cycle after the
  // state is entered on both the normal and the invalid-challenge path.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= S_IDLE;
      timer    <= '0;
      idx_a    <= '0;
      idx_b    <= '0;
      Done     <= 1'b0;
      Response <= 1'b0;
      Tie      <= 1'b0;
      Error    <= 1'b0;
      Count_A  <= '0;
      Count_B  <= '0;
    end else begin
      Done <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (Start) begin
            idx_a    <= chal_a;
            idx_b    <= chal_b;
            Response <= 1'b0;
            Tie      <= 1'b0;
            Count_A  <= '0;
            Count_B  <= '0;
            Error    <= ~chal_ok;
            if (chal_ok) begin
              state <= S_SETTLE;
              timer <= TMR_W'(SETTLE_CYCLES - 1);
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_SETTLE: begin
          if (timer == '0) begin
            state <= S_COUNT;
            timer <= TMR_W'(WINDOW_CYCLES - 1);
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_COUNT: begin
          if (timer == '0) begin
            state <= S_COMPARE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        S_COMPARE: begin
          Count_A  <= cnt_a;
          Count_B  <= cnt_b;
          Response <= (cnt_a > cnt_b);
          Tie      <= (cnt_a == cnt_b);
          state    <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
